// File: rtl/seq_det_pkg.sv
// Shared constants for the parameterised serial pattern detector:
// output-timing and overlap mode selectors plus legal parameter ranges.
package seq_det_pkg;

   localparam int MODE_MOORE = 0;
   localparam int MODE_MEALY = 1;

   localparam int OVL_OFF = 0;
   localparam int OVL_ON  = 1;

   localparam int PAT_W_MIN = 2;
   localparam int PAT_W_MAX = 16;
   localparam int CNT_W_MIN = 2;
   localparam int CNT_W_MAX = 32;

endpackage

// File: rtl/seq_sat_cnt.sv
// Saturating up-counter with a synchronous clear that dominates increment.
module seq_sat_cnt
   import seq_det_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Holds at all-ones once full so a long run of matches never wraps.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_det_param.sv
// Serial pattern detector with loadable pattern, selectable overlap and
// Moore/Mealy output timing, and a saturating match counter.
module seq_det_param
   import seq_det_pkg::*;
#(
   parameter int             PAT_W   = 4,
   parameter int             OVERLAP = OVL_ON,
   parameter int             MEALY   = MODE_MOORE,
   parameter int             CNT_W   = 8,
   parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(4'b1011)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             x,
   input  logic             x_valid,
   input  logic             pat_load,
   input  logic [PAT_W-1:0] pat_in,
   input  logic             cnt_clr,
   output logic             out,
   output logic [CNT_W-1:0] match_cnt
);

   localparam int FILL_W = $clog2(PAT_W + 1);

   if ((PAT_W < PAT_W_MIN) || (PAT_W > PAT_W_MAX)) begin : g_bad_pat_w
      $error("seq_det_param: PAT_W out of range");
   end
   if ((CNT_W < CNT_W_MIN) || (CNT_W > CNT_W_MAX)) begin : g_bad_cnt_w
      $error("seq_det_param: CNT_W out of range");
   end

   logic [PAT_W-1:0]  hist_q, hist_d;
   logic [PAT_W-1:0]  pat_q, pat_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic              moore_q;

   logic [PAT_W-1:0]  hist_shift;
   logic [FILL_W-1:0] fill_inc;
   logic              match;

   // Match is judged on the post-shift view; a load or reset discards the sample.
   always_comb begin
      hist_shift = {hist_q[PAT_W-2:0], x};
      fill_inc   = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + FILL_W'(1);
      match      = x_valid && !pat_load && !rst &&
                   (fill_inc == FILL_W'(PAT_W)) && (hist_shift == pat_q);

      hist_d = hist_q;
      fill_d = fill_q;
      pat_d  = pat_q;
      if (pat_load) begin
         pat_d  = pat_in;
         hist_d = '0;
         fill_d = '0;
      end else if (x_valid) begin
         hist_d = hist_shift;
         fill_d = (match && (OVERLAP == OVL_OFF)) ? '0 : fill_inc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hist_q  <= '0;
         fill_q  <= '0;
         pat_q   <= RST_PAT;
         moore_q <= 1'b0;
      end else begin
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         pat_q   <= pat_d;
         moore_q <= match;
      end
   end

   assign out = rst ? 1'b0 : ((MEALY == MODE_MEALY) ? match : moore_q);

   seq_sat_cnt #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk_i (clk),
      .rst_i (rst),
      .clr_i (cnt_clr),
      .inc_i (match),
      .cnt_o (match_cnt)
   );

endmodule

// File: tb/tb_seq_det_param.sv
// Four detector variants share one stimulus stream; a bit-list reference
// model predicts each one's out/match_cnt and a negedge monitor checks them.
module tb_seq_det_param;
   import seq_det_pkg::*;

   localparam int N  = 4;
   localparam int PW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          x = 1'b0;
   logic          xValid = 1'b0;
   logic          patLoad = 1'b0;
   logic          cntClr = 1'b0;
   logic [PW-1:0] patIn = '0;

   logic       out0, out1, out2, out3;
   logic [7:0] cnt0, cnt1;
   logic [1:0] cnt2;
   logic [2:0] cnt3;

   int total = 0;
   int bad   = 0;

   // Variant table: u0 default, u1 non-overlap Moore, u2 overlap Mealy CNT_W=2, u3 non-overlap Mealy CNT_W=3
   const int ovlCfg[N]   = '{1, 0, 1, 0};
   const int mealyCfg[N] = '{0, 0, 1, 1};
   const int cntMax[N]   = '{255, 255, 3, 7};

   typedef struct {
      bit o;
      int c;
   } exp_t;

   bit   hist[N][$];
   int   patM[N];
   int   cntM[N];
   bit   mooreM[N];
   exp_t expQ[N][$];

   always #5 clk = ~clk;

   seq_det_param #(.PAT_W(PW), .OVERLAP(OVL_ON), .MEALY(MODE_MOORE), .CNT_W(8)) u0 (
      .clk(clk), .rst(rst), .x(x), .x_valid(xValid), .pat_load(patLoad),
      .pat_in(patIn), .cnt_clr(cntClr), .out(out0), .match_cnt(cnt0));
   seq_det_param #(.PAT_W(PW), .OVERLAP(OVL_OFF), .MEALY(MODE_MOORE), .CNT_W(8)) u1 (
      .clk(clk), .rst(rst), .x(x), .x_valid(xValid), .pat_load(patLoad),
      .pat_in(patIn), .cnt_clr(cntClr), .out(out1), .match_cnt(cnt1));
   seq_det_param #(.PAT_W(PW), .OVERLAP(OVL_ON), .MEALY(MODE_MEALY), .CNT_W(2)) u2 (
      .clk(clk), .rst(rst), .x(x), .x_valid(xValid), .pat_load(patLoad),
      .pat_in(patIn), .cnt_clr(cntClr), .out(out2), .match_cnt(cnt2));
   seq_det_param #(.PAT_W(PW), .OVERLAP(OVL_OFF), .MEALY(MODE_MEALY), .CNT_W(3)) u3 (
      .clk(clk), .rst(rst), .x(x), .x_valid(xValid), .pat_load(patLoad),
      .pat_in(patIn), .cnt_clr(cntClr), .out(out3), .match_cnt(cnt3));

   function automatic logic getOut(input int i);
      case (i)
         0:       return out0;
         1:       return out1;
         2:       return out2;
         default: return out3;
      endcase
   endfunction

   function automatic logic [31:0] getCnt(input int i);
      case (i)
         0:       return {24'd0, cnt0};
         1:       return {24'd0, cnt1};
         2:       return {30'd0, cnt2};
         default: return {29'd0, cnt3};
      endcase
   endfunction

   // Drives one cycle of inputs, queues what each variant should show this
   // cycle, then advances the reference model past the coming edge.
   task automatic applyStimulus(input bit r, input bit xv, input bit xb,
                                input bit pl, input int pi, input bit cc);
      @(posedge clk);
      #1;
      rst     = r;
      xValid  = xv;
      x       = xb;
      patLoad = pl;
      patIn   = pi[PW-1:0];
      cntClr  = cc;
      for (int i = 0; i < N; i++) begin
         int   win;
         bit   hit;
         exp_t e;
         hit = 1'b0;
         if (!r && !pl && xv && (hist[i].size() >= PW - 1)) begin
            win = 0;
            for (int k = hist[i].size() - (PW - 1); k < hist[i].size(); k++) begin
               win = win * 2 + int'(hist[i][k]);
            end
            win = win * 2 + int'(xb);
            hit = (win == patM[i]);
         end
         e.o = r ? 1'b0 : ((mealyCfg[i] == 1) ? hit : mooreM[i]);
         e.c = cntM[i];
         expQ[i].push_back(e);
         if (r) begin
            hist[i]   = {};
            patM[i]   = 11;
            cntM[i]   = 0;
            mooreM[i] = 1'b0;
         end else begin
            mooreM[i] = hit;
            if (pl) begin
               patM[i] = pi % 16;
               hist[i] = {};
            end else if (xv) begin
               hist[i].push_back(xb);
               if (hit && ovlCfg[i] == 0) hist[i] = {};
               while (hist[i].size() > PW) void'(hist[i].pop_front());
            end
            if (cc) cntM[i] = 0;
            else if (hit && cntM[i] < cntMax[i]) cntM[i] = cntM[i] + 1;
         end
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] got, input int expv);
      total++;
      if (got !== 32'(expv)) begin
         bad++;
         $display("[TB] FAIL %s got=%0d exp=%0d", name, got, expv);
      end
   endtask

   task automatic doReset();
      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0);
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, 0, 0, 0);
   endtask

   task automatic sendSeq(input logic [15:0] bits, input int n);
      for (int k = n - 1; k >= 0; k--) applyStimulus(0, 1, bits[k], 0, 0, 0);
   endtask

   // Scoreboard: compare whatever the model queued for this cycle.
   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (expQ[i].size() > 0) begin
            exp_t e;
            e = expQ[i].pop_front();
            total++;
            if (getOut(i) !== e.o) begin
               bad++;
               $display("[TB] FAIL out u%0d t=%0t got=%b exp=%b", i, $time, getOut(i), e.o);
            end
            total++;
            if (getCnt(i) !== 32'(e.c)) begin
               bad++;
               $display("[TB] FAIL cnt u%0d t=%0t got=%0d exp=%0d", i, $time, getCnt(i), e.c);
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         patM[i] = 11; cntM[i] = 0; mooreM[i] = 1'b0;
      end

      // Basic overlap vs non-overlap stream 1011011
      doReset();
      @(negedge clk); #1;
      checkOutput("reset cnt u0", getCnt(0), 0);
      checkOutput("reset out u2", 32'(getOut(2)), 0);
      sendSeq(16'b1011011, 7);
      idle();
      @(negedge clk); #1;
      checkOutput("ovl cnt u0", getCnt(0), 2);
      checkOutput("ovl pulse u0", 32'(getOut(0)), 1);
      checkOutput("novl cnt u1", getCnt(1), 1);
      checkOutput("novl out u1", 32'(getOut(1)), 0);

      // Mealy timing with valid gaps
      doReset();
      applyStimulus(0, 1, 1, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 0);
      applyStimulus(0, 1, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 1, 0, 0, 0);
      @(negedge clk); #1;
      checkOutput("mealy same cycle u2", 32'(getOut(2)), 1);
      checkOutput("moore not yet u0", 32'(getOut(0)), 0);
      idle();
      @(negedge clk); #1;
      checkOutput("mealy next cycle u2", 32'(getOut(2)), 0);
      checkOutput("moore pulse u0", 32'(getOut(0)), 1);

      // Saturation with pattern 1111, then clear on a match cycle
      doReset();
      applyStimulus(0, 0, 0, 1, 15, 0);
      sendSeq(16'h7F, 7);
      idle();
      @(negedge clk); #1;
      checkOutput("sat cnt u2", getCnt(2), 3);
      checkOutput("ovl 1111 cnt u0", getCnt(0), 4);
      checkOutput("novl 1111 cnt u1", getCnt(1), 1);
      applyStimulus(0, 1, 1, 0, 0, 1);
      idle();
      @(negedge clk); #1;
      checkOutput("clr wins u0", getCnt(0), 0);
      checkOutput("clr wins u2", getCnt(2), 0);

      // Pattern load discards a simultaneous sample
      doReset();
      sendSeq(16'b101, 3);
      applyStimulus(0, 1, 1, 1, 6, 0);
      sendSeq(16'b0110, 4);
      idle();
      @(negedge clk); #1;
      checkOutput("load cnt u0", getCnt(0), 1);
      checkOutput("load cnt u1", getCnt(1), 1);

      // Reset mid-sequence discards history
      doReset();
      sendSeq(16'b101, 3);
      doReset();
      sendSeq(16'b11011, 5);
      idle();
      @(negedge clk); #1;
      checkOutput("mid reset cnt u0", getCnt(0), 1);
      checkOutput("mid reset cnt u3", getCnt(3), 1);

      // Randomised traffic against the model
      for (int n = 0; n < 3000; n++) begin
         applyStimulus(($urandom_range(0, 99) == 0),
                       ($urandom_range(0, 3) != 0),
                       1'($urandom_range(0, 1)),
                       ($urandom_range(0, 49) == 0),
                       int'($urandom_range(0, 15)),
                       ($urandom_range(0, 29) == 0));
      end
      idle();
      idle();
      @(negedge clk); #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_det_param.md
SEQ_DET_PARAM -- requirements
Module: seq_det_param

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter PAT_W, default 4, pattern length in bits, legal range 2..16.
REQ-003 Parameter OVERLAP, default 1; 1 = overlapping detection, 0 = non-overlapping.
REQ-004 Parameter MEALY, default 0; 1 = Mealy output timing, 0 = Moore output timing.
REQ-005 Parameter CNT_W, default 8, width of the match counter, legal range 2..32.
REQ-006 Parameter RST_PAT, default 4'b1011 zero-extended to PAT_W, pattern loaded at reset.
REQ-007 Port clk, input, 1 bit, rising-edge clock.
REQ-008 Port rst, input, 1 bit, synchronous active-high reset.
REQ-009 Port x, input, 1 bit, serial data bit.
REQ-010 Port x_valid, input, 1 bit; x is sampled only on cycles where x_valid=1.
REQ-011 Port pat_load, input, 1 bit, load strobe for a new pattern.
REQ-012 Port pat_in, input, PAT_W bits; bit PAT_W-1 is the first bit expected in the sequence.
REQ-013 Port cnt_clr, input, 1 bit, clears the match counter.
REQ-014 Port out, output, 1 bit, match indication.
REQ-015 Port match_cnt, output, CNT_W bits, saturating count of matches.

Function
REQ-016 History: a PAT_W-bit shift register plus a fill counter (0..PAT_W). On each valid sample, the history shifts left with x entering at the LSB; the fill counter increments and saturates at PAT_W.
REQ-017 A match occurs on a valid sample when the post-shift fill counter equals PAT_W and the post-shift history equals the stored pattern.
REQ-018 OVERLAP=1: history and fill counter are retained after a match, so suffix bits count toward the next match.
REQ-019 OVERLAP=0: on a match, the fill counter is cleared to 0 on the same edge, so no bit of a matched sequence is reused.
REQ-020 MEALY=1: out is combinational and equals 1 exactly during the cycle in which the matching sample is presented (x_valid=1); latency is 0.
REQ-021 MEALY=0: out is registered and equals 1 for exactly one cycle, on the cycle after the matching sample; latency is 1.
REQ-022 Cycles with x_valid=0 leave the history, fill counter and match counter unchanged; out is 0 in such cycles unless a Moore pulse from the previous cycle is due.
REQ-023 pat_load=1: pat_in is stored on that edge, the history is cleared and the fill counter is zeroed. A simultaneous valid sample is discarded and produces no match; match_cnt is kept.
REQ-024 match_cnt increments by 1 per match and saturates at 2^CNT_W-1.
REQ-025 cnt_clr=1: match_cnt becomes 0. If a match occurs on the same cycle, cnt_clr wins and the result is 0.
REQ-026 Priority order: rst > pat_load > valid sample.

Reset
REQ-027 On rst=1 at a clock edge: history=0, fill=0, pattern=RST_PAT, match_cnt=0, Moore out register=0.
REQ-028 During reset, out=0 in both modes; in Mealy mode, out is gated by rst.
REQ-029 Reset mid-sequence discards partial history; the first match after reset requires PAT_W fresh valid samples.

Structure
REQ-030 Package seq_det_pkg SHALL hold the mode constants MODE_MOORE/MODE_MEALY and OVL_OFF/OVL_ON, plus the PAT_W and CNT_W legal-range limits.
REQ-031 One sub-module, seq_sat_cnt, SHALL implement the CNT_W saturating counter with clear and increment inputs.
REQ-032 An elaboration-time check SHALL reject out-of-range PAT_W and CNT_W.

Verification
REQ-033 PAT_W=4, pattern 1011, OVERLAP=1, MEALY=0, stream 1,0,1,1,0,1,1 (all valid) -> out pulses one cycle after the 4th and 7th samples; match_cnt=2.
REQ-034 Same stream with OVERLAP=0 -> out pulses only after the 4th sample; match_cnt=1.
REQ-035 MEALY=1, pattern 1011, stream 1,0,1,1 -> out=1 in the same cycle as the 4th sample and 0 on the next cycle; x_valid gaps inserted mid-stream do not change the result.
REQ-036 CNT_W=2, repeated pattern 1111 with OVERLAP=1, seven valid 1s -> 4 matches; match_cnt saturates at 3. cnt_clr asserted on a match cycle -> match_cnt=0.
REQ-037 pat_load with pat_in=0110 after samples 1,0,1, with a simultaneous valid x=1 -> no match; the subsequent stream 0,1,1,0 matches exactly once.
REQ-038 rst asserted after samples 1,0,1, then stream 1 -> no match; a full 1,0,1,1 after reset -> exactly one match.
